// File: rtl/dmem_pkg.sv
// Shared types for the dual-port data memory.
// Holds the clear FSM state type and default widths.
package dmem_pkg;

  localparam int DMEM_DATA_W = 8;
  localparam int DMEM_ADDR_W = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dmem_state_t;

endpackage

// File: rtl/dmem_clear_ctrl.sv
// Power-up clear sequencer: sweeps every address with zero, then idles.
// Ports: clk, rst (sync, active-high) in; busy, clr_addr, clr_we out.
module dmem_clear_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_we
);

  dmem_state_t       state;
  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      unique case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          // last word written on this edge
          if (cnt == '1) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          state <= READY;
        end
        default: begin
          state <= CLEAR;
          cnt   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  assign clr_addr = cnt;
  // no sweep write on an edge that is itself a reset edge
  assign clr_we   = (state == CLEAR) && !rst;

endmodule

// File: rtl/dual_port_data_memory.sv
// Two-port synchronous data RAM, zero-cleared by a sweep after reset.
// Ports: CLK, RST, Address/WriteData/MemWriteEnable/ReadData x2, Busy.
// Option: DMEM_BYPASS_EN forwards same-cycle write data to reads.
module dual_port_data_memory
  import dmem_pkg::*;
#(
  parameter int DATA_W  = DMEM_DATA_W,
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int WR_PRIO = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] Address0,
  input  logic [DATA_W-1:0] WriteData0,
  input  logic              MemWriteEnable0,
  output logic [DATA_W-1:0] ReadData0,
  input  logic [ADDR_W-1:0] Address1,
  input  logic [DATA_W-1:0] WriteData1,
  input  logic              MemWriteEnable1,
  output logic [DATA_W-1:0] ReadData1,
  output logic              Busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] clr_addr;
  logic              clr_we;
  logic              act;
  logic              same;
  logic              win0;
  logic              win1;

  dmem_clear_ctrl #(
    .ADDR_W(ADDR_W)
  ) u_clr (
    .clk     (CLK),
    .rst     (RST),
    .busy    (Busy),
    .clr_addr(clr_addr),
    .clr_we  (clr_we)
  );

  assign act  = !Busy && !RST;
  assign same = (Address0 == Address1);

  // losing port of a same-address double write is dropped,
  // so win0 && win1 implies distinct addresses
  assign win0 = act && MemWriteEnable0
             && !(MemWriteEnable1 && same && WR_PRIO != 0);
  assign win1 = act && MemWriteEnable1
             && !(MemWriteEnable0 && same && WR_PRIO == 0);

  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      if (win0) mem[Address0] <= WriteData0;
      if (win1) mem[Address1] <= WriteData1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || Busy) begin
      ReadData0 <= '0;
      ReadData1 <= '0;
    end else begin
      ReadData0 <= mem[Address0];
      ReadData1 <= mem[Address1];
`ifdef DMEM_BYPASS_EN
      if (win0)
        ReadData0 <= WriteData0;
      else if (win1 && same)
        ReadData0 <= WriteData1;
      if (win1)
        ReadData1 <= WriteData1;
      else if (win0 && same)
        ReadData1 <= WriteData0;
`endif
    end
  end

endmodule

// File: tb/tb_dual_port_data_memory.sv
// Randomized bench for dual_port_data_memory against an array model.
// Runs WR_PRIO=1 and WR_PRIO=0 instances side by side on shared inputs.
module tb_dual_port_data_memory;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int DEPTH = 256;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [AW-1:0] a0 = '0;
  logic [AW-1:0] a1 = '0;
  logic [DW-1:0] wd0 = '0;
  logic [DW-1:0] wd1 = '0;
  logic          we0 = 1'b0;
  logic          we1 = 1'b0;
  logic [DW-1:0] rd0 [2];
  logic [DW-1:0] rd1 [2];
  logic          bsy [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  dual_port_data_memory #(
    .DATA_W(DW), .ADDR_W(AW), .WR_PRIO(1)
  ) dut_p1 (
    .CLK(CLK), .RST(RST),
    .Address0(a0), .WriteData0(wd0),
    .MemWriteEnable0(we0), .ReadData0(rd0[1]),
    .Address1(a1), .WriteData1(wd1),
    .MemWriteEnable1(we1), .ReadData1(rd1[1]),
    .Busy(bsy[1])
  );

  dual_port_data_memory #(
    .DATA_W(DW), .ADDR_W(AW), .WR_PRIO(0)
  ) dut_p0 (
    .CLK(CLK), .RST(RST),
    .Address0(a0), .WriteData0(wd0),
    .MemWriteEnable0(we0), .ReadData0(rd0[0]),
    .Address1(a1), .WriteData1(wd1),
    .MemWriteEnable1(we1), .ReadData1(rd1[0]),
    .Busy(bsy[0])
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // model: per-priority word arrays, remaining sweep edges
  logic [DW-1:0] m [2][DEPTH];
  int            sweep = 0;
  bit            mvalid = 0;
  logic [DW-1:0] e_rd0 [2];
  logic [DW-1:0] e_rd1 [2];
  logic          e_busy;

  always @(posedge CLK) begin
    if (RST) begin
      sweep  = DEPTH;
      mvalid = 1;
      for (int p = 0; p < 2; p++) begin
        e_rd0[p] = '0;
        e_rd1[p] = '0;
      end
    end else if (mvalid) begin
      if (sweep > 0) begin
        for (int p = 0; p < 2; p++) begin
          m[p][DEPTH - sweep] = '0;
          e_rd0[p] = '0;
          e_rd1[p] = '0;
        end
        sweep--;
      end else begin
        for (int p = 0; p < 2; p++) begin
`ifndef DMEM_BYPASS_EN
          e_rd0[p] = m[p][a0];
          e_rd1[p] = m[p][a1];
`endif
          if (we0 && we1 && a0 == a1) begin
            m[p][a0] = (p == 1) ? wd1 : wd0;
          end else begin
            if (we0) m[p][a0] = wd0;
            if (we1) m[p][a1] = wd1;
          end
`ifdef DMEM_BYPASS_EN
          e_rd0[p] = m[p][a0];
          e_rd1[p] = m[p][a1];
`endif
        end
      end
    end
    e_busy = (sweep > 0);
    #1;
    if (mvalid) begin
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("busy_p%0d", p), 32'(bsy[p]), 32'(e_busy));
        chk($sformatf("rd0_p%0d", p), 32'(rd0[p]), 32'(e_rd0[p]));
        chk($sformatf("rd1_p%0d", p), 32'(rd1[p]), 32'(e_rd1[p]));
      end
    end
  end

  task automatic idle();
    we0 = 1'b0;
    we1 = 1'b0;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  // hold reset for two edges, release, count edges until Busy drops
  task automatic reset_and_wait(input string nm);
    int n;
    RST = 1'b1;
    cyc(2);
    RST = 1'b0;
    n = 0;
    while (n < 400) begin
      @(posedge CLK);
      #1;
      n++;
      if (!bsy[1]) break;
    end
    chk({nm, "_sweep_len"}, 32'(n), 32'd256);
    @(negedge CLK);
  endtask

  initial begin
    idle();
    cyc(1);
    // cycles 1..256 busy, ready at 257
    reset_and_wait("init");
    chk("busy_after_sweep", 32'(bsy[1]), 32'd0);

    // whole range reads back zero
    for (int i = 0; i < DEPTH; i += 2) begin
      a0 = AW'(i);
      a1 = AW'(i + 1);
      cyc(1);
    end
    cyc(1);
    chk("zero_rd0", 32'(rd0[1]), 32'h00);
    chk("zero_rd1", 32'(rd1[1]), 32'h00);

    // distinct-address double write
    a0 = 8'h10; wd0 = 8'h5A; we0 = 1'b1;
    a1 = 8'h20; wd1 = 8'hA5; we1 = 1'b1;
    cyc(1);
    idle();
    cyc(2);
    chk("dual_wr_p0", 32'(rd0[1]), 32'h5A);
    chk("dual_wr_p1", 32'(rd1[1]), 32'hA5);

    // same-address double write
    a0 = 8'h30; wd0 = 8'h11; we0 = 1'b1;
    a1 = 8'h30; wd1 = 8'h22; we1 = 1'b1;
    cyc(1);
    idle();
    cyc(2);
    chk("prio1_win", 32'(rd1[1]), 32'h22);
    chk("prio0_win", 32'(rd1[0]), 32'h11);

    // read/write collision
    a0 = 8'h40; wd0 = 8'h01; we0 = 1'b1;
    cyc(1);
    idle();
    cyc(1);
    wd0 = 8'h02; we0 = 1'b1; a1 = 8'h40;
    cyc(1);
    idle();
`ifdef DMEM_BYPASS_EN
    chk("collide_rd1", 32'(rd1[1]), 32'h02);
`else
    chk("collide_rd1", 32'(rd1[1]), 32'h01);
`endif
    cyc(1);
    chk("collide_after", 32'(rd1[1]), 32'h02);

    // random traffic, narrow address window half the time
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        a0 = AW'($urandom_range(0, 7));
        a1 = AW'($urandom_range(0, 7));
      end else begin
        a0 = AW'($urandom);
        a1 = AW'($urandom);
      end
      wd0 = DW'($urandom);
      wd1 = DW'($urandom);
      we0 = ($urandom_range(0, 2) == 0);
      we1 = ($urandom_range(0, 2) == 0);
      cyc(1);
    end
    idle();

    // reset pulse mid-sweep restarts the sweep
    a0 = 8'hFF; wd0 = 8'hFF; we0 = 1'b1;
    a1 = 8'h00; wd1 = 8'h77; we1 = 1'b1;
    cyc(1);
    idle();
    RST = 1'b1;
    cyc(1);
    RST = 1'b0;
    cyc(100);
    chk("busy_mid_sweep", 32'(bsy[1]), 32'd1);
    reset_and_wait("restart");
    a0 = 8'hFF; a1 = 8'h00;
    cyc(2);
    chk("restart_rd_ff", 32'(rd0[1]), 32'h00);
    chk("restart_rd_00", 32'(rd1[1]), 32'h00);

    // writes while busy are dropped
    RST = 1'b1;
    cyc(1);
    RST = 1'b0;
    a0 = 8'h05; wd0 = 8'h99; we0 = 1'b1;
    cyc(10);
    chk("busy_rd0_zero", 32'(rd0[1]), 32'h00);
    idle();
    cyc(260);
    chk("ready_again", 32'(bsy[1]), 32'd0);
    a0 = 8'h05;
    cyc(2);
    chk("busy_wr_dropped", 32'(rd0[1]), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dual_port_data_memory.md
DUAL_PORT_DATA_MEMORY -- requirements
Module: dual_port_data_memory

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the data word width in bits.
REQ-002 Parameter ADDR_W, default 8, SHALL set the address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter WR_PRIO, default 1, SHALL select the port (0 or 1) that wins a same-address double write.
REQ-004 CLK  input  1  SHALL be the single clock; all state updates on posedge CLK.
REQ-005 RST  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 Address0  input  ADDR_W  SHALL carry the port 0 (slot 0) word address.
REQ-007 WriteData0  input  DATA_W  SHALL carry the port 0 store data.
REQ-008 MemWriteEnable0  input  1  SHALL request a port 0 write.
REQ-009 ReadData0  output  DATA_W  SHALL return the registered port 0 read data.
REQ-010 Address1, WriteData1, MemWriteEnable1, ReadData1 SHALL mirror REQ-006..009 for port 1 (slot 1).
REQ-011 Busy  output  1  SHALL be high while the clear sweep runs; accesses are ignored.

Function
REQ-012 Clear FSM SHALL have two states, CLEAR and READY; RST forces CLEAR with sweep counter 0.
REQ-013 In CLEAR with RST low, memory[counter] SHALL be written 0 each cycle and counter incremented.
REQ-014 On the edge writing address DEPTH-1, FSM SHALL go to READY; sweep lasts exactly DEPTH cycles after RST release.
REQ-015 Busy SHALL equal (state == CLEAR), registered; it is never combinational from inputs.
REQ-016 While Busy, MemWriteEnable0/1 SHALL be ignored and ReadData0/1 SHALL be held at 0.
REQ-017 In READY, a port with MemWriteEnableN high SHALL write WriteDataN to memory[AddressN] on that edge.
REQ-018 Both ports writing distinct addresses in one cycle SHALL both commit.
REQ-019 Both ports writing the same address in one cycle SHALL commit only port WR_PRIO's data.
REQ-020 Reads SHALL be synchronous: ReadDataN after edge k SHALL reflect memory[AddressN] sampled at edge k, latency 1.
REQ-021 Reads occur every READY cycle regardless of MemWriteEnableN; no read enable exists.
REQ-022 Full address range 0..DEPTH-1 SHALL be valid; no wrap or out-of-range case exists.
REQ-023 Same-cycle read/write collision (either port writing the address either port reads) SHALL follow REQ-027/028.

Reset
REQ-024 RST high at an edge SHALL set state CLEAR, counter 0, ReadData0/1 = 0, Busy = 1.
REQ-025 RST asserted mid-sweep or mid-operation SHALL abort and restart the sweep from address 0 after release.
REQ-026 Memory contents SHALL only be zeroed by the sweep, not by RST itself.

Configuration
REQ-027 With DMEM_BYPASS_EN defined, a read colliding with a same-cycle write SHALL return the committed (post-priority) write data.
REQ-028 Without DMEM_BYPASS_EN, a colliding read SHALL return the pre-write (old) memory value.

Structure
REQ-029 Package dmem_pkg SHALL hold the FSM state typedef (CLEAR, READY) and default DATA_W/ADDR_W constants.
REQ-030 Sub-module dmem_clear_ctrl SHALL contain the FSM and sweep counter, outputting Busy, clear address and clear write strobe.

Verification (DATA_W=8, ADDR_W=8, WR_PRIO=1)
REQ-031 Release RST at cycle 0 -> Busy=1 for cycles 1..256, Busy=0 at 257; every address then reads 0.
REQ-032 Port0 write 0x5A @0x10, port1 write 0xA5 @0x20 same cycle; next cycle read both -> 0x5A, 0xA5.
REQ-033 Both ports write @0x30 (0x11 port0, 0x22 port1) -> later read 0x22; rerun WR_PRIO=0 -> 0x11.
REQ-034 @0x40 holds 0x01; port0 writes 0x02 while port1 reads 0x40 -> ReadData1=0x02 with DMEM_BYPASS_EN, 0x01 without.
REQ-035 Write 0xFF @0xFF and 0x77 @0x00, pulse RST mid-sweep at cycle 100 -> Busy restarts, all reads 0 afterwards.
REQ-036 Assert MemWriteEnable0 with 0x99 @0x05 while Busy -> after READY, read @0x05 returns 0.
